// File: rtl/button_event_arbiter_pkg.sv
// Shared constants and width helpers for the button event arbiter.
package button_event_arbiter_pkg;

  localparam int unsigned TICK_DIV_200US   = 20000;
  localparam int unsigned STABLE_TICKS_DEF = 4;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Press-event valid/ready port; master is the arbiter, slave the consumer.
interface button_event_arbiter_if #(
  parameter int unsigned IDX_W = 2
) ();

  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_idx;
  logic             evt_overflow;

  modport master (output evt_valid, output evt_idx, output evt_overflow, input evt_ready);
  modport slave  (input evt_valid, input evt_idx, input evt_overflow, output evt_ready);

endinterface

// File: rtl/button_debounce_chan.sv
// One button: two-flop synchronizer, tick-based stability counter, clean level and rise pulse.
module button_debounce_chan
  import button_event_arbiter_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  input  logic tick_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned     CntW   = clog2_min1(STABLE_TICKS);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_TICKS - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            rise_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (tick_i) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      // High during the first cycle the new level is visible.
      rise_q  <= level_d & ~level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Debounces N_BTN buttons and serves their press events round-robin on a valid/ready port.
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned IDX_W        = clog2_min1(N_BTN),
  parameter int unsigned TICK_DIV     = TICK_DIV_200US,
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic [N_BTN-1:0]      btn_raw,
  output logic [N_BTN-1:0]      btn_level,
  button_event_arbiter_if.master evt
);

  localparam int unsigned TickW = clog2_min1(TICK_DIV);
  localparam int unsigned NSlot = 2 ** IDX_W;

  logic [TickW-1:0] tick_cnt_q;
  logic             tick;
  logic [N_BTN-1:0] rise;

  logic [N_BTN-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic [NSlot-1:0] pend_ext;
  logic [NSlot-1:0] clear_ext;
  logic [N_BTN-1:0] clear;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;

  assign tick = (tick_cnt_q == TickW'(TICK_DIV - 1));

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .clk_i  (CLK100MHZ),
      .rst_i  (reset),
      .raw_i  (btn_raw[i]),
      .tick_i (tick),
      .level_o(btn_level[i]),
      .rise_o (rise[i])
    );
  end

  assign pend_ext = NSlot'(pending_q);

  // First pending button strictly after the last grant, wrapping at N_BTN.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = last_q;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      cand = (cand == IDX_W'(N_BTN - 1)) ? '0 : cand + IDX_W'(1);
      if (!grant_found && pend_ext[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    valid_d   = valid_q;
    idx_d     = idx_q;
    last_d    = last_q;
    clear_ext = '0;
    if (!valid_q) begin
      if (grant_found) begin
        valid_d   = 1'b1;
        idx_d     = grant_idx;
        last_d    = grant_idx;
        clear_ext = NSlot'(1) << grant_idx;
      end
    end else if (evt.evt_ready) begin
      valid_d = 1'b0;
    end
    clear = clear_ext[N_BTN-1:0];
    // A press landing on the slot being granted re-arms it without counting as lost.
    pending_d = (pending_q & ~clear) | rise;
    ovf_d     = ovf_q | (|(rise & pending_q & ~clear));
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      tick_cnt_q <= '0;
      pending_q  <= '0;
      last_q     <= IDX_W'(N_BTN - 1);
      idx_q      <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TickW'(1);
      pending_q  <= pending_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign evt.evt_valid    = valid_q;
  assign evt.evt_idx      = idx_q;
  assign evt.evt_overflow = ovf_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: per-cycle reference model, vector table, directed corners, random.
module tb_button_event_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TD = 4;
  localparam int ST = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  raw;
  logic          ready;
  logic [N-1:0]  btn_level;

  int n_vec = 0;
  int n_fail = 0;
  int log_q[$];

  button_event_arbiter_if #(.IDX_W(IW)) evt_if ();
  assign evt_if.evt_ready = ready;

  button_event_arbiter #(
    .N_BTN       (N),
    .IDX_W       (IW),
    .TICK_DIV    (TD),
    .STABLE_TICKS(ST)
  ) dut (
    .CLK100MHZ(clk),
    .reset    (reset),
    .btn_raw  (raw),
    .btn_level(btn_level),
    .evt      (evt_if)
  );

  always #5 clk = ~clk;

  // Reference model: values below are what the outputs must be after each edge.
  logic [N-1:0]  m_level, m_h1, m_h2, m_rise, m_pend;
  logic [ST-1:0] m_win [N];
  int            m_edges, m_idx, m_last;
  logic          m_valid, m_ovf;

  task automatic model_step();
    logic         tk, found;
    logic [N-1:0] sync, press, clr;
    int           j;
    if (reset) begin
      m_level = '0; m_h1 = '0; m_h2 = '0; m_rise = '0; m_pend = '0;
      for (int b = 0; b < N; b++) m_win[b] = '0;
      m_edges = 0; m_idx = 0; m_last = N - 1; m_valid = 1'b0; m_ovf = 1'b0;
    end else begin
      tk = ((m_edges % TD) == TD - 1);
      m_edges++;
      sync = m_h2; m_h2 = m_h1; m_h1 = raw;
      press = m_rise; m_rise = '0;
      clr = '0; found = 1'b0;
      if (!m_valid) begin
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (!found && m_pend[j]) begin
            found = 1'b1; m_valid = 1'b1; m_idx = j; m_last = j; clr[j] = 1'b1;
          end
        end
      end else if (ready) begin
        m_valid = 1'b0;
      end
      for (int b = 0; b < N; b++)
        if (press[b] && m_pend[b] && !clr[b]) m_ovf = 1'b1;
      m_pend = (m_pend & ~clr) | press;
      // Level flips once the last ST tick samples all disagree with it.
      if (tk) begin
        for (int b = 0; b < N; b++) begin
          m_win[b] = {m_win[b][ST-2:0], sync[b]};
          if (m_win[b] == {ST{~m_level[b]}}) begin
            m_level[b] = ~m_level[b];
            if (m_level[b]) m_rise[b] = 1'b1;
          end
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: log a handshake about to happen, then compare against the model.
  task automatic cyc();
    if (evt_if.evt_valid && ready && !reset) log_q.push_back(int'(evt_if.evt_idx));
    @(negedge clk);
    chk("level", 32'(btn_level), 32'(m_level));
    chk("valid", 32'(evt_if.evt_valid), 32'(m_valid));
    if (m_valid) chk("idx", 32'(evt_if.evt_idx), 32'(m_idx));
    chk("overflow", 32'(evt_if.evt_overflow), 32'(m_ovf));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  typedef struct {
    logic [N-1:0] raw;
    logic         rdy;
    int           cycles;
    logic [N-1:0] lvl;
    logic         vld;
    int           idx;
    logic         ovf;
  } vec_t;

  vec_t tbl[8];
  int   n2;

  initial begin
    tbl[0] = '{4'b0001, 1'b1, 30, 4'b0001, 1'b0, 0, 1'b0};
    tbl[1] = '{4'b0000, 1'b1, 30, 4'b0000, 1'b0, 0, 1'b0};
    tbl[2] = '{4'b0001, 1'b0, 30, 4'b0001, 1'b1, 0, 1'b0};
    tbl[3] = '{4'b0101, 1'b0, 30, 4'b0101, 1'b1, 0, 1'b0};
    tbl[4] = '{4'b0001, 1'b0, 30, 4'b0001, 1'b1, 0, 1'b0};
    tbl[5] = '{4'b0101, 1'b0, 30, 4'b0101, 1'b1, 0, 1'b1};
    tbl[6] = '{4'b0101, 1'b1, 30, 4'b0101, 1'b0, 0, 1'b1};
    tbl[7] = '{4'b0000, 1'b1, 30, 4'b0000, 1'b0, 0, 1'b1};

    // Reset with all buttons held; outputs stay clear until 3 ticks after release.
    reset = 1'b1; raw = 4'b1111; ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_level", 32'(btn_level), 32'h0);
      chk("rst_valid", 32'(evt_if.evt_valid), 32'h0);
      chk("rst_idx", 32'(evt_if.evt_idx), 32'h0);
      chk("rst_ovf", 32'(evt_if.evt_overflow), 32'h0);
    end
    reset = 1'b0; ready = 1'b1;
    run(11);
    chk("level_before_3rd_tick", 32'(btn_level), 32'h0);
    cyc();
    chk("level_at_3rd_tick", 32'(btn_level), 32'hf);
    run(20);
    raw = '0;
    run(30);

    // Clean press and release of button 0.
    log_q.delete();
    raw = 4'b0001;
    run(30);
    chk("b0_events", log_q.size(), 1);
    if (log_q.size() > 0) chk("b0_idx", log_q[0], 0);
    raw = '0;
    run(30);
    chk("b0_release_level", 32'(btn_level), 32'h0);
    chk("b0_release_events", log_q.size(), 1);

    // Bouncing button 1: never three disagreeing ticks in a row.
    log_q.delete();
    for (int c = 0; c < 80; c++) begin
      raw[1] = ((c / 8) % 2) == 1;
      cyc();
      chk("bounce_level1", 32'(btn_level[1]), 32'h0);
    end
    raw = '0;
    run(20);
    chk("bounce_events", log_q.size(), 0);

    // Simultaneous presses with the consumer stalled, then round-robin order.
    ready = 1'b0; raw = 4'b1010;
    run(30);
    chk("stall_valid", 32'(evt_if.evt_valid), 32'h1);
    chk("stall_idx", 32'(evt_if.evt_idx), 32'h1);
    for (int c = 0; c < 20; c++) begin
      cyc();
      chk("held_idx", 32'(evt_if.evt_idx), 32'h1);
    end
    log_q.delete();
    ready = 1'b1;
    run(10);
    chk("rr_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("rr_first", log_q[0], 1);
      chk("rr_second", log_q[1], 3);
    end
    raw = '0;
    run(30);
    log_q.delete();
    raw = 4'b0011;
    run(30);
    chk("rr2_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("rr2_first", log_q[0], 0);
      chk("rr2_second", log_q[1], 1);
    end
    raw = '0;
    run(30);

    // Vector table: settled outputs after each phase, including overflow on btn2.
    log_q.delete();
    for (int v = 0; v < 8; v++) begin
      raw = tbl[v].raw; ready = tbl[v].rdy;
      run(tbl[v].cycles);
      chk($sformatf("tbl%0d_level", v), 32'(btn_level), 32'(tbl[v].lvl));
      chk($sformatf("tbl%0d_valid", v), 32'(evt_if.evt_valid), 32'(tbl[v].vld));
      if (tbl[v].vld) chk($sformatf("tbl%0d_idx", v), 32'(evt_if.evt_idx), 32'(tbl[v].idx));
      chk($sformatf("tbl%0d_ovf", v), 32'(evt_if.evt_overflow), 32'(tbl[v].ovf));
    end
    n2 = 0;
    foreach (log_q[i]) if (log_q[i] == 2) n2++;
    chk("tbl_idx2_events", n2, 1);

    // Reset while an event is outstanding and button 3 is pending.
    ready = 1'b0; raw = 4'b0001;
    run(30);
    raw = 4'b1001;
    run(30);
    chk("pre_rst_valid", 32'(evt_if.evt_valid), 32'h1);
    reset = 1'b1; raw = '0;
    cyc();
    chk("midrst_valid", 32'(evt_if.evt_valid), 32'h0);
    chk("midrst_ovf", 32'(evt_if.evt_overflow), 32'h0);
    reset = 1'b0; ready = 1'b1;
    log_q.delete();
    run(40);
    chk("post_rst_events", log_q.size(), 0);

    // Random buttons, ready and occasional resets against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) raw[$urandom_range(0, N - 1)] ^= 1'b1;
      ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 599) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
